// File: rtl/alu_seq.sv
// Handshaked, registered ALU with one-bit-per-cycle shifts/rotates.
// Define ALU_MUL_EN to build op 13 as an iterative shift-add multiplier; otherwise op 13 is reserved.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             overflow,
    output logic             less,
    output logic             equal,
    output logic             greater,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NEG = 4'd2;
    localparam logic [3:0] OP_CMP = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_ASR = 4'd8;
    localparam logic [3:0] OP_LSR = 4'd9;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;
    localparam logic [3:0] OP_LSL = 4'd12;

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd13;
    localparam logic [SHW:0] MUL_CNT = (SHW+1)'(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

    state_t           r_state, w_state_next;
    logic [SHW:0]     r_cnt, w_cnt_next;
    logic [WIDTH-1:0] r_val, w_val_next;
    logic [3:0]       r_op;

    logic             w_accept;
    logic             w_is_shift;
    logic             w_k_zero;

    logic [WIDTH:0]   w_add, w_sub;
    logic [WIDTH-1:0] w_sub_a;
    logic [WIDTH-1:0] w_sc_q;
    logic             w_sc_c, w_sc_v, w_sc_lt, w_sc_eq, w_sc_gt;

    logic [WIDTH-1:0] w_sh_val;
    logic             w_sh_bit;

    logic             w_done;
    logic [WIDTH-1:0] w_res_q;
    logic             w_res_c, w_res_v, w_res_lt, w_res_eq, w_res_gt;

    logic [WIDTH-1:0] r_q;
    logic             r_out_valid, r_carry, r_ov, r_lt, r_eq, r_gt, r_zero;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] r_acc, r_mcand, w_acc_next;
    logic [WIDTH-1:0]   r_mplier;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`endif

    // A new op may enter only when idle and the output slot is free or draining this cycle.
    assign in_ready   = rst_n && (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_shift = (op >= OP_ASR) && (op <= OP_LSL);
    assign w_k_zero   = (a[SHW-1:0] == '0);

    // Single-cycle results; NEG reuses the subtractor with a zero minuend.
    always_comb begin
        w_sub_a = (op == OP_NEG) ? '0 : a;
        w_add   = {1'b0, a} + {1'b0, b};
        w_sub   = {1'b0, w_sub_a} - {1'b0, b};
        w_sc_q  = '0;
        w_sc_c  = 1'b0;
        w_sc_v  = 1'b0;
        w_sc_lt = 1'b0;
        w_sc_eq = 1'b0;
        w_sc_gt = 1'b0;
        case (op)
            OP_ADD: begin
                w_sc_q = w_add[MSB:0];
                w_sc_c = w_add[WIDTH];
                w_sc_v = (a[MSB] == b[MSB]) && (w_add[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP, OP_NEG: begin
                w_sc_q = w_sub[MSB:0];
                w_sc_c = ~w_sub[WIDTH];
                w_sc_v = (w_sub_a[MSB] != b[MSB]) && (w_sub[MSB] != w_sub_a[MSB]);
                if (op != OP_NEG) begin
                    w_sc_lt = $signed(a) <  $signed(b);
                    w_sc_eq = a == b;
                    w_sc_gt = $signed(a) >  $signed(b);
                end
            end
            OP_AND: w_sc_q = a & b;
            OP_OR:  w_sc_q = a | b;
            OP_XOR: w_sc_q = a ^ b;
            OP_NOT: w_sc_q = ~b;
            OP_ASR, OP_LSR, OP_ROL, OP_ROR, OP_LSL: w_sc_q = b;
            default: ;
        endcase
    end

    // One-bit step of the latched shift/rotate; w_sh_bit is the bit leaving the word.
    always_comb begin
        w_sh_val = r_val;
        w_sh_bit = 1'b0;
        case (r_op)
            OP_ASR: begin w_sh_val = {r_val[MSB], r_val[MSB:1]};  w_sh_bit = r_val[0];   end
            OP_LSR: begin w_sh_val = {1'b0, r_val[MSB:1]};        w_sh_bit = r_val[0];   end
            OP_ROL: begin w_sh_val = {r_val[MSB-1:0], r_val[MSB]}; w_sh_bit = r_val[MSB]; end
            OP_ROR: begin w_sh_val = {r_val[0], r_val[MSB:1]};    w_sh_bit = r_val[0];   end
            OP_LSL: begin w_sh_val = {r_val[MSB-1:0], 1'b0};      w_sh_bit = r_val[MSB]; end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_val_next   = r_val;
        w_done       = 1'b0;
        w_res_q      = '0;
        w_res_c      = 1'b0;
        w_res_v      = 1'b0;
        w_res_lt     = 1'b0;
        w_res_eq     = 1'b0;
        w_res_gt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_shift && !w_k_zero) begin
                        w_state_next = S_SHIFT;
                        w_cnt_next   = {1'b0, a[SHW-1:0]};
                        w_val_next   = b;
`ifdef ALU_MUL_EN
                    end else if (op == OP_MUL) begin
                        w_state_next = S_MUL;
                        w_cnt_next   = MUL_CNT;
`endif
                    end else begin
                        w_done   = 1'b1;
                        w_res_q  = w_sc_q;
                        w_res_c  = w_sc_c;
                        w_res_v  = w_sc_v;
                        w_res_lt = w_sc_lt;
                        w_res_eq = w_sc_eq;
                        w_res_gt = w_sc_gt;
                    end
                end
            end
            S_SHIFT: begin
                if (r_cnt == 1) begin
                    w_done       = 1'b1;
                    w_res_q      = w_sh_val;
                    w_res_c      = w_sh_bit;
                    w_state_next = S_IDLE;
                end else begin
                    w_val_next = w_sh_val;
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                if (r_cnt == 1) begin
                    w_done       = 1'b1;
                    w_res_q      = w_acc_next[MSB:0];
                    w_res_v      = |w_acc_next[2*WIDTH-1:WIDTH];
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_val <= '0;
            r_op  <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            r_val <= w_val_next;
            if (w_accept) r_op <= op;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (w_accept && op == OP_MUL) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end
`endif

    // Result and flags only change on a new result, so they hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_carry     <= 1'b0;
            r_ov        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_done) begin
            r_out_valid <= 1'b1;
            r_q         <= w_res_q;
            r_carry     <= w_res_c;
            r_ov        <= w_res_v;
            r_lt        <= w_res_lt;
            r_eq        <= w_res_eq;
            r_gt        <= w_res_gt;
            r_zero      <= (w_res_q == '0);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign carry     = r_carry;
    assign overflow  = r_ov;
    assign less      = r_lt;
    assign equal     = r_eq;
    assign greater   = r_gt;
    assign zero      = r_zero;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq (WIDTH=16) against an arithmetic reference model.
// Honors ALU_MUL_EN the same way as the design.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic        carry, overflow, less, equal, greater, zero;

    int total = 0;
    int bad   = 0;
    bit bp_mode  = 1'b0;
    bit bp_force = 1'b1;

    typedef struct packed {
        logic [15:0] q;
        logic        c, v, lt, eq, gt, z;
        logic [7:0]  lat;
    } res_t;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .carry(carry), .overflow(overflow),
        .less(less), .equal(equal), .greater(greater), .zero(zero)
    );

    always #5 clk = ~clk;

    // Expected result of one operation, straight from the arithmetic definitions.
    function automatic res_t model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        res_t r;
        int sa, sb, s;
        int unsigned ua, ub, k, p;
        r  = '0;
        sa = $signed(x);
        sb = $signed(y);
        ua = x;
        ub = y;
        k  = ua % 16;
        p  = 0;
        r.lat = 8'd1;
        case (o)
            4'd0: begin
                s = sa + sb;
                r.q = 16'(ua + ub);
                r.c = (ua + ub) > 65535;
                r.v = (s > 32767) || (s < -32768);
            end
            4'd1, 4'd3: begin
                s = sa - sb;
                r.q = 16'(ua - ub);
                r.c = ua >= ub;
                r.v = (s > 32767) || (s < -32768);
                r.lt = sa < sb;
                r.eq = sa == sb;
                r.gt = sa > sb;
            end
            4'd2: begin
                s = -sb;
                r.q = 16'(0 - ub);
                r.c = ub == 0;
                r.v = s > 32767;
            end
            4'd4: r.q = x & y;
            4'd5: r.q = x | y;
            4'd6: r.q = x ^ y;
            4'd7: r.q = ~y;
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12: begin
                r.lat = 8'(k + 1);
                r.q = y;
                if (k != 0) begin
                    case (o)
                        4'd8:  begin r.q = 16'($signed(y) >>> k); r.c = y[k-1]; end
                        4'd9:  begin r.q = y >> k;                r.c = y[k-1]; end
                        4'd10: begin r.q = 16'((ub << k) | (ub >> (16 - k))); r.c = r.q[0]; end
                        4'd11: begin r.q = 16'((ub >> k) | (ub << (16 - k))); r.c = r.q[15]; end
                        default: begin r.q = y << k;              r.c = y[16-k]; end
                    endcase
                end
            end
`ifdef ALU_MUL_EN
            4'd13: begin
                p = ua * ub;
                r.q = p[15:0];
                r.v = p[31:16] != 0;
                r.lat = 8'd17;
            end
`endif
            default: ;
        endcase
        r.z = r.q == 16'd0;
        return r;
    endfunction

    function automatic res_t mk(input logic [15:0] qq, input logic c, v, lt, eq, gt, z, input logic [7:0] lat);
        res_t r;
        r.q = qq; r.c = c; r.v = v; r.lt = lt; r.eq = eq; r.gt = gt; r.z = z; r.lat = lat;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pin(input string name, input logic [3:0] o, input logic [15:0] x, y, input res_t exp);
        res_t r;
        r = model(o, x, y);
        check(name, 32'(r), 32'(exp));
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        bit got;
        got = 1'b0;
        op = o; a = x; b = y; in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a  = 16'($urandom);
        b  = 16'($urandom);
        op = 4'($urandom);
        if (!got) check("send_timeout", 32'd0, 32'd1);
        else $display("txn op=%0d a=%h b=%h", o, x, y);
    endtask

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : bp_force;
        end
    end

    // Reference timeline: one pending op, one output slot, checked every cycle.
    initial begin : compare
        int   n;
        int   pend_cycle;
        bit   have_pend;
        bit   exp_valid;
        bit   m_ready;
        res_t pend_res, cur_res;
        n = 0; pend_cycle = 0; have_pend = 0; exp_valid = 0;
        pend_res = '0; cur_res = '0;
        forever begin
            @(negedge clk);
            n++;
            if (!rst_n) begin
                have_pend = 0;
                exp_valid = 0;
                check("reset_outputs",
                      32'({in_ready, out_valid, q, carry, overflow, less, equal, greater, zero}), 32'd0);
                continue;
            end
            if (have_pend && pend_cycle == n) begin
                exp_valid = 1;
                cur_res   = pend_res;
                have_pend = 0;
            end
            m_ready = !have_pend && (!exp_valid || out_ready);
            check("in_ready", 32'(in_ready), 32'(m_ready));
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid)
                check("result", 32'({q, carry, overflow, less, equal, greater, zero}),
                      32'({cur_res.q, cur_res.c, cur_res.v, cur_res.lt, cur_res.eq, cur_res.gt, cur_res.z}));
            if (exp_valid && out_ready) exp_valid = 0;
            if (in_valid && m_ready) begin
                pend_res   = model(op, a, b);
                pend_cycle = n + int'(pend_res.lat);
                have_pend  = 1;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;

        pin("pin_add_ovf", 4'd0,  16'h7FFF, 16'h0001, mk(16'h8000, 0, 1, 0, 0, 0, 0, 8'd1));
        pin("pin_sub_lt",  4'd1,  16'h0003, 16'h0005, mk(16'hFFFE, 0, 0, 1, 0, 0, 0, 8'd1));
        pin("pin_cmp_eq",  4'd3,  16'h1234, 16'h1234, mk(16'h0000, 1, 0, 0, 1, 0, 1, 8'd1));
        pin("pin_neg_min", 4'd2,  16'h0000, 16'h8000, mk(16'h8000, 0, 1, 0, 0, 0, 0, 8'd1));
        pin("pin_asr4",    4'd8,  16'h0004, 16'h8010, mk(16'hF801, 0, 0, 0, 0, 0, 0, 8'd5));
        pin("pin_ror1",    4'd11, 16'h0001, 16'h0001, mk(16'h8000, 1, 0, 0, 0, 0, 0, 8'd2));
        pin("pin_lsl_k0",  4'd12, 16'h0010, 16'h0001, mk(16'h0001, 0, 0, 0, 0, 0, 0, 8'd1));
        pin("pin_rsvd",    4'd15, 16'hFFFF, 16'hFFFF, mk(16'h0000, 0, 0, 0, 0, 0, 1, 8'd1));
`ifdef ALU_MUL_EN
        pin("pin_mul",     4'd13, 16'h0100, 16'h0100, mk(16'h0000, 0, 1, 0, 0, 0, 1, 8'd17));
`else
        pin("pin_mul",     4'd13, 16'h0100, 16'h0100, mk(16'h0000, 0, 0, 0, 0, 0, 1, 8'd1));
`endif

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back single-cycle ops, then the directed multi-cycle cases.
        send(4'd0, 16'h7FFF, 16'h0001);
        send(4'd0, 16'hFFFF, 16'h0001);
        send(4'd0, 16'h8000, 16'h8000);
        send(4'd1, 16'h0003, 16'h0005);
        send(4'd3, 16'h1234, 16'h1234);
        send(4'd2, 16'h0000, 16'h8000);
        send(4'd8, 16'h0004, 16'h8010);
        send(4'd11, 16'h0001, 16'h0001);
        send(4'd13, 16'h0100, 16'h0100);
        send(4'd13, 16'h1234, 16'h0ABC);
        send(4'd14, 16'h1111, 16'h2222);

        // Backpressure: XOR result held while a following ADD waits.
        bp_force = 1'b0;
        @(posedge clk); #1;
        send(4'd6, 16'hA5A5, 16'h0FF0);
        fork
            send(4'd0, 16'h0001, 16'h0002);
            begin
                repeat (3) @(posedge clk);
                bp_force = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;

        // Reset in the middle of a long shift.
        send(4'd12, 16'h000A, 16'h00FF);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk); #1;

        bp_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            send(4'($urandom), 16'($urandom), 16'($urandom));
        end
        bp_mode  = 1'b0;
        bp_force = 1'b1;
        repeat (40) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
